// File: rtl/wb_regfile.sv
// Writeback stage fused with the 32x32 register file: selects writeback data, commits it,
// serves two bypassed combinational read ports and counts retired instructions.
module wb_regfile #(
    parameter int unsigned RETIRE_CNT_WIDTH  = 32,
    parameter bit          RESET_CLEARS_REGS = 1'b1
) (
    input  logic                        Clk_40,
    input  logic                        Reset,
    input  logic [31:0]                 ALUResult_WB_40,
    input  logic [31:0]                 ReadDataFromMem_WB_40,
    input  logic [31:0]                 Instruction_WB_40,
    input  logic                        MemtoReg_WB_40,
    input  logic                        RegWrite_WB_40,
    input  logic [31:0]                 NextInstruct_WB_40,
    input  logic [4:0]                  WriteRegAddress_WB_40,
    input  logic [4:0]                  ReadAddr1_40,
    input  logic [4:0]                  ReadAddr2_40,
    output logic [31:0]                 ReadData1_40,
    output logic [31:0]                 ReadData2_40,
    output logic [31:0]                 WBWriteData_40,
    output logic                        WBWriteEn_40,
    output logic [4:0]                  WBWriteAddr_40,
    output logic [RETIRE_CNT_WIDTH-1:0] RetiredCount_40
);

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] FunctJalr = 6'h09;

    logic                        link;
    logic [31:0]                 wb_data;
    logic                        wb_en;
    logic [31:0]                 regs_q [32];
    logic [RETIRE_CNT_WIDTH-1:0] retired_q, retired_d;

    always_comb begin
        link = (Instruction_WB_40[31:26] == OpJal) ||
               ((Instruction_WB_40[31:26] == OpSpecial) &&
                (Instruction_WB_40[5:0] == FunctJalr));
        if (MemtoReg_WB_40) begin
            wb_data = ReadDataFromMem_WB_40;
        end else if (link) begin
            wb_data = NextInstruct_WB_40;
        end else begin
            wb_data = ALUResult_WB_40;
        end
        // Gating by Reset here also drops any write that coincides with reset.
        wb_en = RegWrite_WB_40 && (WriteRegAddress_WB_40 != 5'd0) && !Reset;
    end

    assign WBWriteData_40 = wb_data;
    assign WBWriteEn_40   = wb_en;
    assign WBWriteAddr_40 = WriteRegAddress_WB_40;

    always_ff @(posedge Clk_40) begin
        if (Reset) begin
            if (RESET_CLEARS_REGS) begin
                for (int i = 0; i < 32; i++) begin
                    regs_q[i] <= '0;
                end
            end
        end else if (wb_en) begin
            regs_q[WriteRegAddress_WB_40] <= wb_data;
        end
    end

    // Write-then-read: a same-cycle write to the addressed register is visible immediately.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (Reset || (addr == 5'd0)) begin
            return 32'h0;
        end else if (wb_en && (addr == WriteRegAddress_WB_40)) begin
            return wb_data;
        end else begin
            return regs_q[addr];
        end
    endfunction

    always_comb begin
        ReadData1_40 = read_port(ReadAddr1_40);
        ReadData2_40 = read_port(ReadAddr2_40);
    end

    // Bubbles (all-zero words) are not counted; stores and branches are.
    always_comb begin
        retired_d = retired_q;
        if (Reset) begin
            retired_d = '0;
        end else if (Instruction_WB_40 != 32'h0) begin
            retired_d = retired_q + RETIRE_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk_40) begin
        retired_q <= retired_d;
    end

    assign RetiredCount_40 = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile: a driver pushes expected outputs from an
// array-based reference model, a monitor pops and compares them mid-cycle.
module tb_wb_regfile;

    localparam int unsigned CntW = 4;
    localparam logic [31:0] InstrAdd  = 32'h0000_0020;
    localparam logic [31:0] InstrJal  = 32'h0C00_0010;
    localparam logic [31:0] InstrJalr = 32'h03E0_0009;

    logic            Clk_40 = 1'b0;
    logic            Reset;
    logic [31:0]     ALUResult_WB_40, ReadDataFromMem_WB_40, Instruction_WB_40;
    logic            MemtoReg_WB_40, RegWrite_WB_40;
    logic [31:0]     NextInstruct_WB_40;
    logic [4:0]      WriteRegAddress_WB_40, ReadAddr1_40, ReadAddr2_40;
    logic [31:0]     ReadData1_40, ReadData2_40, WBWriteData_40;
    logic            WBWriteEn_40;
    logic [4:0]      WBWriteAddr_40;
    logic [CntW-1:0] RetiredCount_40;

    always #5 Clk_40 = ~Clk_40;

    wb_regfile #(
        .RETIRE_CNT_WIDTH (CntW),
        .RESET_CLEARS_REGS(1'b1)
    ) dut (
        .Clk_40               (Clk_40),
        .Reset                (Reset),
        .ALUResult_WB_40      (ALUResult_WB_40),
        .ReadDataFromMem_WB_40(ReadDataFromMem_WB_40),
        .Instruction_WB_40    (Instruction_WB_40),
        .MemtoReg_WB_40       (MemtoReg_WB_40),
        .RegWrite_WB_40       (RegWrite_WB_40),
        .NextInstruct_WB_40   (NextInstruct_WB_40),
        .WriteRegAddress_WB_40(WriteRegAddress_WB_40),
        .ReadAddr1_40         (ReadAddr1_40),
        .ReadAddr2_40         (ReadAddr2_40),
        .ReadData1_40         (ReadData1_40),
        .ReadData2_40         (ReadData2_40),
        .WBWriteData_40       (WBWriteData_40),
        .WBWriteEn_40         (WBWriteEn_40),
        .WBWriteAddr_40       (WBWriteAddr_40),
        .RetiredCount_40      (RetiredCount_40)
    );

    typedef struct {
        logic [31:0]     rd1;
        logic [31:0]     rd2;
        logic [31:0]     wd;
        logic            we;
        logic [4:0]      wa;
        logic [CntW-1:0] cnt;
        bit              chk_wd;
        bit              chk_cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    int unsigned m_cnt;
    bit          cnt_known;
    bit          x_instr;
    int unsigned n_vec;
    int unsigned n_miss;

    function automatic logic [31:0] model_read(input bit rst, input bit we, input logic [4:0] wa,
                                               input logic [31:0] wd, input logic [4:0] ra);
        if (rst || ra == 5'd0) return 32'h0;
        if (we && ra == wa) return wd;
        return m_regs[ra];
    endfunction

    task automatic step(input bit rst, input bit rw, input bit m2r, input logic [31:0] instr,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] nxt,
                        input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
        bit          link;
        logic [31:0] wd;
        bit          we;
        exp_t        e;
        @(posedge Clk_40);
        #1;
        Reset = rst; RegWrite_WB_40 = rw; MemtoReg_WB_40 = m2r; Instruction_WB_40 = instr;
        ALUResult_WB_40 = alu; ReadDataFromMem_WB_40 = mem; NextInstruct_WB_40 = nxt;
        WriteRegAddress_WB_40 = wa; ReadAddr1_40 = ra1; ReadAddr2_40 = ra2;
        link = !x_instr && ((instr[31:26] == 6'h03) ||
                            (instr[31:26] == 6'h00 && instr[5:0] == 6'h09));
        wd = m2r ? mem : (link ? nxt : alu);
        we = rw && (wa != 5'd0) && !rst;
        e.rd1 = model_read(rst, we, wa, wd, ra1);
        e.rd2 = model_read(rst, we, wa, wd, ra2);
        e.wd = wd;
        e.we = we;
        e.wa = wa;
        e.cnt = CntW'(m_cnt);
        e.chk_wd = !x_instr || m2r;
        e.chk_cnt = cnt_known;
        exp_q.push_back(e);
        if (rst) begin
            m_cnt = 0;
            cnt_known = 1'b1;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            if (we) m_regs[wa] = wd;
            if (x_instr) cnt_known = 1'b0;
            else if (instr != 32'h0) m_cnt = (m_cnt + 1) % (1 << CntW);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk_40);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ReadData1", ReadData1_40, e.rd1);
                chk("ReadData2", ReadData2_40, e.rd2);
                chk("WBWriteEn", 32'(WBWriteEn_40), 32'(e.we));
                chk("WBWriteAddr", 32'(WBWriteAddr_40), 32'(e.wa));
                if (e.chk_wd) chk("WBWriteData", WBWriteData_40, e.wd);
                if (e.chk_cnt) chk("RetiredCount", 32'(RetiredCount_40), 32'(e.cnt));
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return {6'h03, r[25:0]};
            2:       return {6'h00, r[19:0], 6'h09};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [4:0] wa;
        n_vec = 0; n_miss = 0; m_cnt = 0; cnt_known = 1'b1; x_instr = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        Reset = 1'b1; RegWrite_WB_40 = 1'b0; MemtoReg_WB_40 = 1'b0; Instruction_WB_40 = '0;
        ALUResult_WB_40 = '0; ReadDataFromMem_WB_40 = '0; NextInstruct_WB_40 = '0;
        WriteRegAddress_WB_40 = '0; ReadAddr1_40 = '0; ReadAddr2_40 = '0;
        repeat (2) @(posedge Clk_40);

        // Reset state on every address of both ports
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        // ALU write with same-cycle bypass, then array read
        step(0, 1, 0, InstrAdd, 32'hDEAD_BEEF, 32'h0, 32'h0, 5, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

        // Load beats link; jal and jalr both select the link value
        step(0, 1, 1, InstrJal, 32'h1111, 32'h1234, 32'h400, 3, 3, 0);
        step(0, 1, 0, InstrJal, 32'h2222, 32'h5555, 32'h400, 31, 3, 31);
        step(0, 1, 0, InstrJalr, 32'h3333, 32'h6666, 32'h400, 30, 31, 30);
        step(0, 0, 0, 0, 0, 0, 0, 0, 31, 30);

        // Writes to $zero are discarded but still retire
        step(0, 1, 0, InstrAdd, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 3 bubbles + 17 instructions wrap a 4-bit counter to 1
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, (i == 2 || i == 9 || i == 15) ? 32'h0 : (rand_instr() | 32'h1),
                 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset concurrent with a write drops it; the next write commits
        step(0, 1, 0, InstrAdd, 32'h1357_9BDF, 0, 0, 7, 0, 0);
        step(1, 1, 0, InstrAdd, 32'hA5A5_A5A5, 0, 0, 7, 7, 7);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        step(0, 1, 0, InstrAdd, 32'h5A5A_5A5A, 0, 0, 7, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wa = 5'($urandom);
            step(($urandom_range(39) == 0), 1'($urandom), 1'($urandom), rand_instr(),
                 $urandom, $urandom, $urandom, wa,
                 ($urandom_range(2) == 0) ? wa : 5'($urandom), 5'($urandom));
        end

        // Unknown instruction without RegWrite must leave the file untouched
        x_instr = 1'b1;
        step(0, 0, 0, 32'hxxxx_xxxx, $urandom, $urandom, $urandom, 5'($urandom), 1, 2);
        x_instr = 1'b0;
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        repeat (3) @(posedge Clk_40);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage fused with the 32x32 general-purpose register file.
- Selects writeback data (memory load, ALU result or link address), commits it to the register file on Clk_40, and serves two combinational ID-stage read ports with write-through bypass.
- Maintains a retired-instruction counter and a writeback-forwarding output for the EX-stage forwarding unit.

Parameters:
- RETIRE_CNT_WIDTH, 32, width of retired-instruction counter; wraps modulo 2^RETIRE_CNT_WIDTH.
- RESET_CLEARS_REGS, 1, 1 = reset zeroes all 32 registers; 0 = reset clears only the counter and forwarding state.

Ports:
- Clk_40  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ALUResult_WB_40  in  32  ALU result from MEM/WB.
- ReadDataFromMem_WB_40  in  32  load data from MEM/WB.
- Instruction_WB_40  in  32  instruction word in WB; 32'h0 = bubble.
- MemtoReg_WB_40  in  1  1 selects load data.
- RegWrite_WB_40  in  1  write enable from MEM/WB.
- NextInstruct_WB_40  in  32  PC+4 of the WB instruction, used as the link value.
- WriteRegAddress_WB_40  in  5  destination register.
- ReadAddr1_40  in  5  ID read port 1 address.
- ReadAddr2_40  in  5  ID read port 2 address.
- ReadData1_40  out  32  ID read port 1 data, combinational.
- ReadData2_40  out  32  ID read port 2 data, combinational.
- WBWriteData_40  out  32  selected writeback data, combinational, for forwarding.
- WBWriteEn_40  out  1  effective write enable: RegWrite & addr!=0 & !Reset.
- WBWriteAddr_40  out  5  equal to WriteRegAddress_WB_40.
- RetiredCount_40  out  RETIRE_CNT_WIDTH  number of non-bubble instructions retired.

Behaviour:
- Link detect: Link = (opcode [31:26]==6'h03, jal) OR (opcode==6'h00 AND funct [5:0]==6'h09, jalr).
- Data select, with strict priority: MemtoReg=1 -> ReadDataFromMem; else Link=1 -> NextInstruct; else ALUResult.
- Write: on rising Clk_40, if WBWriteEn_40, regs[WriteRegAddress] <= WBWriteData_40. Single-cycle commit; no further latency.
- Register 0: reads always 0. A write to address 0 is discarded and WBWriteEn_40 stays 0.
- Read port n, combinational:
  - Reset=1 -> 0.
  - else ReadAddr=0 -> 0.
  - else WBWriteEn_40 & ReadAddr==WBWriteAddr_40 -> WBWriteData_40 (same-cycle bypass, write-then-read semantics).
  - else regs[ReadAddr].
- Both ports may read the same address simultaneously; each bypasses independently.
- Retire counter: on rising edge, if !Reset and Instruction_WB_40 != 0, increment by 1, independent of RegWrite (stores and branches count). All-ones wraps to 0.
- Reset (edge with Reset=1):
  - RetiredCount_40 <= 0.
  - If RESET_CLEARS_REGS, all regs <= 0.
  - Any concurrent write is dropped.
  - Outputs during the reset cycle: ReadData1/2_40 = 0, WBWriteEn_40 = 0. WBWriteData_40 and WBWriteAddr_40 continue to follow their inputs.
- Reset asserted mid-stream: the in-flight WB instruction is neither committed nor counted. The first edge after Reset deasserts commits normally.
- X-safety: an unknown Instruction_WB_40 with RegWrite=0 must not corrupt any register.
- No internal stall input; MEM/WB holds or bubbles upstream.

Test Plan:
- Reset for 1 cycle, then read all 32 addresses on both ports -> every ReadData = 0; RetiredCount_40 = 0.
- ALU write: RegWrite=1, MemtoReg=0, addr=5, ALUResult=32'hDEADBEEF, Instruction=add -> WBWriteData=32'hDEADBEEF; ReadAddr1=5 returns it in the same cycle (bypass) and on the next cycle from the array; count=1.
- Load vs link priority: MemtoReg=1, Instruction=jal (32'h0C000010), load data=32'h1234, NextInstruct=32'h400 -> 32'h1234 written. Then MemtoReg=0, jal, addr=31 -> regs[31]=32'h400. Repeat with jalr -> same result.
- $zero: write 32'hFFFFFFFF to addr 0 -> WBWriteEn=0; ReadData1/2 for addr 0 read 0; count still increments.
- Bubbles and wrap: with RETIRE_CNT_WIDTH=4, drive 3 bubbles and 17 non-zero instructions -> count = 1 (wrapped); bubbles not counted.
- Reset mid-write: RegWrite=1, addr=7, data=32'hA5A5A5A5 with Reset=1 in the same cycle -> regs[7] = 0 after reset; count = 0; the write on the next cycle (Reset=0) commits.
